vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_VISIBLE, default 480: active lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 Parameter PIPE_DLY, default 1: pixel-source latency in cycles, from x_ptr/y_ptr to valid RGB; range 0..4.
REQ-010 clk_vga  in  1: pixel clock, 25 MHz nominal; the block has no other clock.
REQ-011 rst_n  in  1: asynchronous, active-low reset.
REQ-012 RGB  in  8: pixel colour from the display selector, packed {R[7:5],G[4:2],B[1:0]}.
REQ-013 x_ptr  out  10: current horizontal count.
REQ-014 y_ptr  out  10: current vertical count.
REQ-015 video_on  out  1: undelayed active-area flag, aligned to x_ptr/y_ptr.
REQ-016 line_tick  out  1: one-cycle pulse at the last pixel of each line.
REQ-017 frame_tick  out  1: one-cycle pulse at the last pixel of each frame.
REQ-018 vga_hsync, vga_vsync  out  1 each: active-low sync outputs to the pins.
REQ-019 vga_r  out  3, vga_g  out  3, vga_b  out  2: registered colour outputs to the pins.

Function
REQ-020 HT = H_VISIBLE+H_FP+H_SYNC+H_BP (800 at defaults); VT = V_VISIBLE+V_FP+V_SYNC+V_BP (525 at defaults).
REQ-021 The horizontal counter h_cnt SHALL increment every clk_vga cycle and wrap from HT-1 to 0.
REQ-022 The vertical counter v_cnt SHALL increment only in the cycle h_cnt wraps, and SHALL wrap from VT-1 to 0 when both counters wrap together.
REQ-023 x_ptr = h_cnt and y_ptr = v_cnt, both driven directly from the counter registers.
REQ-024 video_on = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
REQ-025 line_tick = (h_cnt == HT-1); frame_tick = line_tick && (v_cnt == VT-1).
REQ-026 The raw hsync SHALL be low while h_cnt is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. 656..751 at defaults.
REQ-027 The raw vsync SHALL be low while v_cnt is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], i.e. 490..491 at defaults.
REQ-028 Raw hsync, raw vsync and video_on SHALL pass through a PIPE_DLY-stage shift register; PIPE_DLY=0 means a direct connection.
REQ-029 Output register: vga_hsync and vga_vsync SHALL take the delayed sync values.
REQ-030 In the same output register, {vga_r,vga_g,vga_b} SHALL take RGB when delayed video_on is 1, and 0 otherwise.
REQ-031 Total latency from a counter value to its pin outputs SHALL be PIPE_DLY+1 cycles.
REQ-032 RGB SHALL be sampled only in the cycle described in REQ-030; RGB values in blanking SHALL never reach the pins.
REQ-033 All comparisons SHALL be unsigned and 10-bit, with no overflow for HT, VT ≤ 1023.

Reset
REQ-034 While rst_n=0, the block SHALL hold h_cnt=0, v_cnt=0 and colour outputs=0.
REQ-035 While rst_n=0, vga_hsync=1, vga_vsync=1, and every delay stage SHALL hold its inactive value (sync 1, video_on 0).
REQ-036 Asserting rst_n mid-frame SHALL clear all state immediately, without waiting for a clock edge.
REQ-037 After rst_n deasserts, the first rising edge of clk_vga SHALL advance h_cnt to 1; x_ptr=0/y_ptr=0 is presented while reset is held.

Verification
REQ-038 Free-run from reset for 2 frames -> frame_tick pulses exactly every 420000 cycles; line_tick exactly every 800 cycles; exactly 525 line_ticks per frame.
REQ-039 Hsync timing at defaults, PIPE_DLY=1 -> vga_hsync falls 2 cycles after h_cnt=656; stays low for 96 cycles.
REQ-040 Vsync timing at defaults -> vga_vsync is low for exactly 1600 cycles per frame, starting at line 490.
REQ-041 Drive RGB=8'hE3 constantly -> pins show r=7, g=0, b=3 only where the 2-cycle-delayed video_on is 1; pins are 0 in blanking.
REQ-042 Drive RGB=x_ptr[7:0], PIPE_DLY=1 -> the pin value at pixel column c equals (c-1) mod 256, consistent with the 1-cycle source model.
REQ-043 Pulse rst_n low at h=300, v=200 -> outputs go to reset values asynchronously; after release, x_ptr/y_ptr restart from 0,0 and the next frame_tick arrives 420000 cycles later.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: horizontal/vertical counters, sync generation and a
// registered colour/sync pin stage that tracks a fixed pixel-source latency.
module vga_timing_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_DLY  = 1
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic [7:0] RGB,
  output logic [9:0] x_ptr,
  output logic [9:0] y_ptr,
  output logic       video_on,
  output logic       line_tick,
  output logic       frame_tick,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b
);

  localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(HT - 1);
  localparam logic [9:0] V_LAST   = 10'(VT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       hsync_dly;
  logic       vsync_dly;
  logic       video_dly;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign x_ptr      = h_cnt;
  assign y_ptr      = v_cnt;
  assign video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign line_tick  = (h_cnt == H_LAST);
  assign frame_tick = line_tick && (v_cnt == V_LAST);
  assign hsync_raw  = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
  assign vsync_raw  = !((v_cnt >= VS_START) && (v_cnt <= VS_END));

  // Delay the timing flags so they line up with the pixel source's colour.
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign hsync_dly = hsync_raw;
      assign vsync_dly = vsync_raw;
      assign video_dly = video_on;
    end else begin : g_dly
      logic hs_sh  [PIPE_DLY];
      logic vs_sh  [PIPE_DLY];
      logic vid_sh [PIPE_DLY];
      for (genvar gi = 0; gi < PIPE_DLY; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge clk_vga or negedge rst_n) begin
            if (!rst_n) begin
              hs_sh[0]  <= 1'b1;
              vs_sh[0]  <= 1'b1;
              vid_sh[0] <= 1'b0;
            end else begin
              hs_sh[0]  <= hsync_raw;
              vs_sh[0]  <= vsync_raw;
              vid_sh[0] <= video_on;
            end
          end
        end else begin : g_next
          always_ff @(posedge clk_vga or negedge rst_n) begin
            if (!rst_n) begin
              hs_sh[gi]  <= 1'b1;
              vs_sh[gi]  <= 1'b1;
              vid_sh[gi] <= 1'b0;
            end else begin
              hs_sh[gi]  <= hs_sh[gi-1];
              vs_sh[gi]  <= vs_sh[gi-1];
              vid_sh[gi] <= vid_sh[gi-1];
            end
          end
        end
      end
      assign hsync_dly = hs_sh[PIPE_DLY-1];
      assign vsync_dly = vs_sh[PIPE_DLY-1];
      assign video_dly = vid_sh[PIPE_DLY-1];
    end
  endgenerate

  // Colour is gated here so blanking-interval RGB never reaches the pins.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      {vga_r, vga_g, vga_b} <= 8'h00;
    end else begin
      vga_hsync <= hsync_dly;
      vga_vsync <= vsync_dly;
      {vga_r, vga_g, vga_b} <= video_dly ? RGB : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a reduced raster (16x9 totals) so full frames
// run quickly; a cycle-index model derives every output arithmetically.
module tb_vga_timing_ctrl;

  localparam int HV  = 8;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 3;
  localparam int VV  = 4;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int PD  = 1;
  localparam int HT  = HV + HFP + HS + HBP;
  localparam int VT  = VV + VFP + VS + VBP;

  logic       clk_vga = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] RGB     = 8'h00;
  logic [9:0] x_ptr, y_ptr;
  logic       video_on, line_tick, frame_tick, vga_hsync, vga_vsync;
  logic [2:0] vga_r, vga_g;
  logic [1:0] vga_b;

  vga_timing_ctrl #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .PIPE_DLY(PD)
  ) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .RGB(RGB),
    .x_ptr(x_ptr), .y_ptr(y_ptr), .video_on(video_on),
    .line_tick(line_tick), .frame_tick(frame_tick),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk_vga = ~clk_vga;

  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  int         k        = 0;
  int         mode     = 0;
  logic [7:0] hist [0:1023];
  int         ft1, ft2, lt_cnt, hs_low, vs_low, hs_first, vs_first;

  function automatic int hm(int i); return i % HT; endfunction
  function automatic int vm(int i); return (i / HT) % VT; endfunction

  task automatic check(string name, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s k=%0d actual=%0d required=%0d", name, k, act, exp);
  endtask

  task automatic drive_rgb();
    logic [7:0] v;
    case (mode)
      0:       v = 8'hE3;
      1:       v = 8'(hm(k));
      default: v = 8'($urandom_range(0, 255));
    endcase
    RGB     = v;
    hist[k] = v;
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_x"}, int'(x_ptr), 0);
    check({tag, "_y"}, int'(y_ptr), 0);
    check({tag, "_hs"}, int'(vga_hsync), 1);
    check({tag, "_vs"}, int'(vga_vsync), 1);
    check({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
  endtask

  // Cycle-by-cycle comparison against the raster model.
  task automatic check_cycle();
    int j, ehs, evs, ecol;
    check("x_ptr", int'(x_ptr), hm(k));
    check("y_ptr", int'(y_ptr), vm(k));
    check("video_on", int'(video_on), int'(hm(k) < HV && vm(k) < VV));
    check("line_tick", int'(line_tick), int'(hm(k) == HT - 1));
    check("frame_tick", int'(frame_tick), int'(hm(k) == HT - 1 && vm(k) == VT - 1));
    j = k - 1 - PD;
    if (j < 0) begin
      ehs = 1; evs = 1; ecol = 0;
    end else begin
      ehs  = int'(!(hm(j) >= HV + HFP && hm(j) <= HV + HFP + HS - 1));
      evs  = int'(!(vm(j) >= VV + VFP && vm(j) <= VV + VFP + VS - 1));
      ecol = (hm(j) < HV && vm(j) < VV) ? int'(hist[k-1]) : 0;
    end
    check("vga_hsync", int'(vga_hsync), ehs);
    check("vga_vsync", int'(vga_vsync), evs);
    check("pins_rgb", int'({vga_r, vga_g, vga_b}), ecol);
  endtask

  task automatic clear_stats();
    ft1 = -1; ft2 = -1; lt_cnt = 0; hs_low = 0; vs_low = 0;
    hs_first = -1; vs_first = -1;
  endtask

  task automatic step();
    @(posedge clk_vga);
    #1;
    k++;
    drive_rgb();
    @(negedge clk_vga);
    check_cycle();
    if (frame_tick === 1'b1) begin
      if (ft1 < 0) ft1 = k;
      else if (ft2 < 0) ft2 = k;
    end
    if (line_tick === 1'b1) lt_cnt++;
    if (vga_hsync === 1'b0 && k <= HT) begin
      hs_low++;
      if (hs_first < 0) hs_first = k;
    end
    if (vga_vsync === 1'b0 && k <= HT * VT) begin
      vs_low++;
      if (vs_first < 0) vs_first = k;
    end
  endtask

  task automatic release_reset();
    @(negedge clk_vga);
    k = 0;
    clear_stats();
    drive_rgb();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_stats();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_vga);
    @(negedge clk_vga);
    check_reset_state("rst_hold");
    release_reset();

    // Two frames of constant colour 8'hE3.
    mode = 0;
    for (int n = 0; n < 2 * HT * VT; n++) begin
      step();
      if (k == 20) begin
        check("e3_r", int'(vga_r), 7);
        check("e3_g", int'(vga_g), 0);
        check("e3_b", int'(vga_b), 3);
      end
      if (k == 30) check("e3_blank", int'({vga_r, vga_g, vga_b}), 0);
    end
    check("ft_first_k", ft1, HT * VT - 1);
    check("ft_period", ft2 - ft1, HT * VT);
    check("line_ticks_2fr", lt_cnt, 2 * VT);
    check("hs_first_low_k", hs_first, HV + HFP + PD + 1);
    check("hs_low_len", hs_low, HS);
    check("vs_first_low_k", vs_first, (VV + VFP) * HT + PD + 1);
    check("vs_low_len", vs_low, VS * HT);

    // Colour ramp following the column: pins show (column - 1).
    mode = 1;
    for (int n = 0; n < HT * VT; n++) begin
      step();
      if (k == 308) begin
        check("ramp_x", int'(x_ptr), 4);
        check("ramp_pin", int'({vga_r, vga_g, vga_b}), 3);
      end
    end

    // Random colour, then an asynchronous mid-frame reset.
    mode = 2;
    for (int n = 0; n < 68; n++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(posedge clk_vga);
    #1;
    check_reset_state("rst_edge");
    release_reset();
    for (int n = 0; n < HT * VT + 4; n++) step();
    check("post_rst_ft_k", ft1, HT * VT - 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
